// File: rtl/l1_request_responder_if.sv
// l1_request_responder_if: processor, directory and invalidation channels of the L1 responder.
// Rev 1.0
`default_nettype none

interface l1_request_responder_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              proc_valid;
  logic              proc_op;
  logic [ADDR_W-1:0] proc_addr;
  logic [DATA_W-1:0] proc_data;
  logic              proc_ready;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_data;

  logic              dir_req_valid;
  logic [1:0]        dir_req_type;
  logic [ADDR_W-1:0] dir_req_addr;
  logic [DATA_W-1:0] dir_req_data;
  logic              dir_req_ready;
  logic              dir_rsp_valid;
  logic [DATA_W-1:0] dir_rsp_data;

  logic              inv_valid;
  logic [ADDR_W-1:0] inv_addr;
  logic              inv_ready;
  logic              inv_ack;
  logic              inv_dirty;
  logic [DATA_W-1:0] inv_data;

  modport master (
    output proc_valid, proc_op, proc_addr, proc_data,
    input  proc_ready, resp_valid, resp_data,
    input  dir_req_valid, dir_req_type, dir_req_addr, dir_req_data,
    output dir_req_ready, dir_rsp_valid, dir_rsp_data,
    output inv_valid, inv_addr,
    input  inv_ready, inv_ack, inv_dirty, inv_data
  );

  modport slave (
    input  proc_valid, proc_op, proc_addr, proc_data,
    output proc_ready, resp_valid, resp_data,
    output dir_req_valid, dir_req_type, dir_req_addr, dir_req_data,
    input  dir_req_ready, dir_rsp_valid, dir_rsp_data,
    input  inv_valid, inv_addr,
    output inv_ready, inv_ack, inv_dirty, inv_data
  );
endinterface

`default_nettype wire

// File: rtl/l1_request_responder.sv
// l1_request_responder: direct-mapped MSI L1 that serves processor instructions and directory invalidations.
// Rev 1.0
`default_nettype none

module l1_request_responder #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int LINES  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  l1_request_responder_if.slave bus
);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - IDX_W;
  localparam logic [1:0] REQ_GETS = 2'b00;
  localparam logic [1:0] REQ_GETM = 2'b01;
  localparam logic [1:0] REQ_WB   = 2'b10;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WB_REQ    = 3'd1,
    MISS_REQ  = 3'd2,
    MISS_WAIT = 3'd3,
    RESP      = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    LN_I = 2'd0,
    LN_S = 2'd1,
    LN_M = 2'd2
  } line_t;

  state_t state, state_nx;

  line_t             line_st   [LINES];
  logic [TAG_W-1:0]  line_tag  [LINES];
  logic [DATA_W-1:0] line_data [LINES];

  logic              op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              inv_ack_q;
  logic              inv_dirty_q;
  logic [DATA_W-1:0] inv_data_q;

  logic [IDX_W-1:0] acc_idx, cur_idx, inv_idx;
  logic [TAG_W-1:0] acc_tag, cur_tag, inv_tag;
  logic             accept, acc_hit, inv_fire, inv_hit;

  assign acc_idx = bus.proc_addr[IDX_W-1:0];
  assign acc_tag = bus.proc_addr[ADDR_W-1:IDX_W];
  assign cur_idx = addr_q[IDX_W-1:0];
  assign cur_tag = addr_q[ADDR_W-1:IDX_W];
  assign inv_idx = bus.inv_addr[IDX_W-1:0];
  assign inv_tag = bus.inv_addr[ADDR_W-1:IDX_W];

  // An invalidation presented in IDLE blocks acceptance in the same cycle.
  assign accept   = (state == IDLE) && bus.proc_valid && !bus.inv_valid;
  assign acc_hit  = (line_st[acc_idx] != LN_I) && (line_tag[acc_idx] == acc_tag);
  assign inv_fire = bus.inv_valid && ((state == IDLE) || (state == MISS_WAIT));
  assign inv_hit  = (line_st[inv_idx] != LN_I) && (line_tag[inv_idx] == inv_tag);

  assign bus.inv_ack   = inv_ack_q;
  assign bus.inv_dirty = inv_dirty_q;
  assign bus.inv_data  = inv_data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx          = state;
    bus.proc_ready    = 1'b0;
    bus.resp_valid    = 1'b0;
    bus.resp_data     = '0;
    bus.dir_req_valid = 1'b0;
    bus.dir_req_type  = REQ_GETS;
    bus.dir_req_addr  = '0;
    bus.dir_req_data  = '0;
    bus.inv_ready     = 1'b0;
    case (state)
      IDLE: begin
        bus.proc_ready = !bus.inv_valid;
        bus.inv_ready  = 1'b1;
        if (accept) begin
          if (acc_hit && (!bus.proc_op || line_st[acc_idx] == LN_M))
            state_nx = RESP;
          else if (!acc_hit && line_st[acc_idx] == LN_M)
            state_nx = WB_REQ;
          else
            state_nx = MISS_REQ;
        end
      end
      WB_REQ: begin
        bus.dir_req_valid = 1'b1;
        bus.dir_req_type  = REQ_WB;
        bus.dir_req_addr  = {line_tag[cur_idx], cur_idx};
        bus.dir_req_data  = line_data[cur_idx];
        if (bus.dir_req_ready) state_nx = MISS_REQ;
      end
      MISS_REQ: begin
        bus.dir_req_valid = 1'b1;
        bus.dir_req_type  = op_q ? REQ_GETM : REQ_GETS;
        bus.dir_req_addr  = addr_q;
        if (bus.dir_req_ready) state_nx = MISS_WAIT;
      end
      MISS_WAIT: begin
        bus.inv_ready = 1'b1;
        if (bus.dir_rsp_valid) state_nx = RESP;
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        bus.resp_data  = line_data[cur_idx];
        state_nx       = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LINES; i++) begin
        line_st[i]   <= LN_I;
        line_tag[i]  <= '0;
        line_data[i] <= '0;
      end
      op_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      inv_ack_q   <= 1'b0;
      inv_dirty_q <= 1'b0;
      inv_data_q  <= '0;
    end else begin
      inv_ack_q   <= inv_fire;
      inv_dirty_q <= inv_fire && inv_hit && (line_st[inv_idx] == LN_M);
      inv_data_q  <= (inv_fire && inv_hit) ? line_data[inv_idx] : '0;
      if (inv_fire && inv_hit) line_st[inv_idx] <= LN_I;

      if (accept) begin
        op_q    <= bus.proc_op;
        addr_q  <= bus.proc_addr;
        wdata_q <= bus.proc_data;
        if (bus.proc_op && acc_hit && line_st[acc_idx] == LN_M)
          line_data[acc_idx] <= bus.proc_data;
      end

      if (state == WB_REQ && bus.dir_req_ready) line_st[cur_idx] <= LN_I;

      // Placed after the invalidation so a same-cycle fill of that line wins.
      if (state == MISS_WAIT && bus.dir_rsp_valid) begin
        line_tag[cur_idx]  <= cur_tag;
        line_st[cur_idx]   <= op_q ? LN_M : LN_S;
        line_data[cur_idx] <= op_q ? wdata_q : bus.dir_rsp_data;
      end
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_l1_request_responder.sv
// tb_l1_request_responder: directed plus randomized checks against a transaction-level cache model.
// Rev 1.0
`default_nettype none

module tb_l1_request_responder;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int LINES  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  l1_request_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  l1_request_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINES(LINES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Model line states: 0 invalid, 1 shared, 2 modified.
  int         m_st   [4];
  logic [5:0] m_tag  [4];
  logic [7:0] m_data [4];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_st[i] = 0; m_tag[i] = '0; m_data[i] = '0;
    end
  endtask

  task automatic idle_inputs();
    bus.proc_valid = 1'b0; bus.proc_op = 1'b0; bus.proc_addr = '0; bus.proc_data = '0;
    bus.dir_req_ready = 1'b0; bus.dir_rsp_valid = 1'b0; bus.dir_rsp_data = '0;
    bus.inv_valid = 1'b0; bus.inv_addr = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_proc_ready"}, bus.proc_ready, 1);
    check_eq({tag, "_inv_ready"}, bus.inv_ready, 1);
    check_eq({tag, "_resp"}, {bus.resp_valid, bus.resp_data}, 0);
    check_eq({tag, "_dir_req"}, {bus.dir_req_valid, bus.dir_req_type, bus.dir_req_addr, bus.dir_req_data}, 0);
    check_eq({tag, "_inv_out"}, {bus.inv_ack, bus.inv_dirty, bus.inv_data}, 0);
  endtask

  // Model invalidation: returns expected dirty/data and updates the model.
  task automatic model_inv(input logic [7:0] a, output logic dirty, output logic [7:0] data);
    logic [1:0] ix;
    bit hit;
    ix = a[1:0];
    hit = (m_st[ix] != 0) && (m_tag[ix] == a[7:2]);
    dirty = hit && (m_st[ix] == 2);
    data = hit ? m_data[ix] : 8'h00;
    if (hit) m_st[ix] = 0;
  endtask

  task automatic do_inv(input logic [7:0] a, input bit with_proc);
    logic       e_dirty;
    logic [7:0] e_data;
    bus.inv_valid = 1'b1;
    bus.inv_addr  = a;
    if (with_proc) begin
      bus.proc_valid = 1'b1;
      bus.proc_op    = 1'($urandom_range(0, 1));
      bus.proc_addr  = 8'($urandom_range(0, 255));
      bus.proc_data  = 8'($urandom_range(0, 255));
    end
    #1;
    check_eq("inv_ready", bus.inv_ready, 1);
    check_eq("inv_blocks_proc_ready", bus.proc_ready, 0);
    model_inv(a, e_dirty, e_data);
    @(negedge clk);
    bus.inv_valid  = 1'b0;
    bus.proc_valid = 1'b0;
    check_eq("inv_ack", bus.inv_ack, 1);
    check_eq("inv_dirty", bus.inv_dirty, e_dirty);
    check_eq("inv_data", bus.inv_data, e_data);
    check_eq("inv_no_accept_resp", bus.resp_valid, 0);
    check_eq("inv_no_accept_req", bus.dir_req_valid, 0);
    @(negedge clk);
    check_eq("inv_ack_pulse", bus.inv_ack, 0);
    check_eq("inv_back_idle", bus.proc_ready, 1);
  endtask

  task automatic send_req(input logic [1:0] ty, input logic [7:0] ad, input logic [7:0] da, input int rdly);
    for (int k = 0; k <= rdly; k++) begin
      check_eq("req_valid", bus.dir_req_valid, 1);
      check_eq("req_type", bus.dir_req_type, ty);
      check_eq("req_addr", bus.dir_req_addr, ad);
      check_eq("req_data", bus.dir_req_data, da);
      if (k == rdly) bus.dir_req_ready = 1'b1;
      @(negedge clk);
    end
    bus.dir_req_ready = 1'b0;
  endtask

  // Issues one instruction and plays the directory; starts and ends at a negedge in IDLE.
  task automatic run_instr(input bit op, input logic [7:0] a, input logic [7:0] d, input logic [7:0] rsp,
                           input int rdly, input bit inj_inv, input logic [7:0] inv_a);
    logic [1:0] ix;
    logic [5:0] t;
    bit         hit;
    logic       e_dirty;
    logic [7:0] e_idata;
    ix  = a[1:0];
    t   = a[7:2];
    hit = (m_st[ix] != 0) && (m_tag[ix] == t);
    bus.proc_valid = 1'b1;
    bus.proc_op    = op;
    bus.proc_addr  = a;
    bus.proc_data  = d;
    #1 check_eq("proc_ready_idle", bus.proc_ready, 1);
    @(negedge clk);
    bus.proc_valid = 1'b0;
    if (hit && (!op || m_st[ix] == 2)) begin
      if (op) m_data[ix] = d;
      check_eq("hit_resp_valid", bus.resp_valid, 1);
      check_eq("hit_resp_data", bus.resp_data, m_data[ix]);
      check_eq("hit_no_req", bus.dir_req_valid, 0);
      check_eq("hit_busy", bus.proc_ready, 0);
    end else begin
      if (!hit && m_st[ix] == 2) begin
        send_req(2'b10, {m_tag[ix], ix}, m_data[ix], rdly);
        m_st[ix] = 0;
      end
      send_req(op ? 2'b01 : 2'b00, a, 8'h00, rdly);
      repeat ($urandom_range(0, 3)) begin
        check_eq("wait_no_req", bus.dir_req_valid, 0);
        check_eq("wait_no_resp", bus.resp_valid, 0);
        check_eq("wait_inv_ready", bus.inv_ready, 1);
        @(negedge clk);
      end
      bus.dir_rsp_valid = 1'b1;
      bus.dir_rsp_data  = rsp;
      if (inj_inv) begin
        bus.inv_valid = 1'b1;
        bus.inv_addr  = inv_a;
        model_inv(inv_a, e_dirty, e_idata);
      end
      @(negedge clk);
      bus.dir_rsp_valid = 1'b0;
      bus.inv_valid     = 1'b0;
      m_tag[ix]  = t;
      m_st[ix]   = op ? 2 : 1;
      m_data[ix] = op ? d : rsp;
      check_eq("miss_resp_valid", bus.resp_valid, 1);
      check_eq("miss_resp_data", bus.resp_data, m_data[ix]);
      if (inj_inv) begin
        check_eq("wait_inv_ack", bus.inv_ack, 1);
        check_eq("wait_inv_dirty", bus.inv_dirty, e_dirty);
        check_eq("wait_inv_data", bus.inv_data, e_idata);
      end
    end
    @(negedge clk);
    check_eq("resp_pulse", bus.resp_valid, 0);
    check_eq("resp_data_zero", bus.resp_data, 0);
    check_eq("ready_again", bus.proc_ready, 1);
  endtask

  task automatic reset_mid(input bit in_wait);
    bus.proc_valid = 1'b1;
    bus.proc_op    = 1'b0;
    bus.proc_addr  = 8'h05;
    @(negedge clk);
    bus.proc_valid = 1'b0;
    check_eq("rm_req_valid", bus.dir_req_valid, 1);
    if (in_wait) begin
      bus.dir_req_ready = 1'b1;
      @(negedge clk);
      bus.dir_req_ready = 1'b0;
      check_eq("rm_in_wait", bus.dir_req_valid, 0);
    end
    #2 rst = 1'b1;
    #1 check_reset_outputs("rm_async");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check_eq("rm_no_resp", bus.resp_valid, 0);
    @(negedge clk);
    check_eq("rm_no_resp2", bus.resp_valid, 0);
  endtask

  initial begin
    logic [7:0] ra;
    idle_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_outputs("reset_held");
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset_released");

    run_instr(1'b0, 8'h05, 8'h00, 8'hAA, 1, 1'b0, 8'h00);
    run_instr(1'b0, 8'h05, 8'h00, 8'h00, 0, 1'b0, 8'h00);
    run_instr(1'b1, 8'h05, 8'h78, 8'h11, 0, 1'b0, 8'h00);
    run_instr(1'b0, 8'h05, 8'h00, 8'h00, 0, 1'b0, 8'h00);
    run_instr(1'b1, 8'h09, 8'h48, 8'h22, 3, 1'b0, 8'h00);
    do_inv(8'h09, 1'b1);
    run_instr(1'b0, 8'h09, 8'h00, 8'h5C, 0, 1'b0, 8'h00);
    do_inv(8'h33, 1'b0);
    run_instr(1'b1, 8'h09, 8'h66, 8'h77, 0, 1'b1, 8'h09);

    reset_mid(1'b0);
    reset_mid(1'b1);
    run_instr(1'b0, 8'h05, 8'h00, 8'h3C, 0, 1'b0, 8'h00);

    for (int n = 0; n < 250; n++) begin
      ra = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 15));
      if ($urandom_range(0, 4) == 0)
        do_inv(ra, 1'($urandom_range(0, 1)));
      else
        run_instr(1'($urandom_range(0, 1)), ra, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                  int'($urandom_range(0, 2)), $urandom_range(0, 3) == 0, 8'($urandom_range(0, 15)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

`default_nettype wire
